mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 19 +
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mul_div_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_UDIV = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int ITERATIONS = 64;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        SIGNFIX,
        FINISH
    } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 64-bit multiply / restoring divide, one bit per cycle.
// Define MUL_DIV_SDIV_EN to add signed division (Op = 10).
module mul_div_unit
    import mul_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [63:0] Result,
    output logic        DivByZero
);

    state_e         state_q, state_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [127:0]   acc_q, acc_d;
    logic [63:0]    b_q, b_d;
    logic [63:0]    result_q, result_d;
    logic           dbz_q, dbz_d;
    logic           last;
    logic           is_div;
    logic [64:0]    mul_sum;
    logic [64:0]    div_rem;
    logic [64:0]    div_diff;

`ifdef MUL_DIV_SDIV_EN
    logic           sdiv_q, sdiv_d;
    logic           neg_q, neg_d;
    assign is_div = (Op == OP_UDIV) || (Op == OP_SDIV);
`else
    assign is_div = (Op == OP_UDIV);
`endif

    assign last     = (cnt_q == 7'(ITERATIONS - 1));
    // acc holds {product, multiplier} for MUL, {remainder, quotient} for DIV
    assign mul_sum  = {1'b0, acc_q[127:64]} + {1'b0, (acc_q[0] ? b_q : 64'd0)};
    assign div_rem  = acc_q[127:63];
    assign div_diff = div_rem - {1'b0, b_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Op == OP_MUL) begin
                        state_d = MUL;
                    end else if (is_div && (B != '0)) begin
                        state_d = DIV;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            MUL: begin
                if (last) state_d = FINISH;
            end
            DIV: begin
                if (last) begin
`ifdef MUL_DIV_SDIV_EN
                    state_d = sdiv_q ? SIGNFIX : FINISH;
`else
                    state_d = FINISH;
`endif
                end
            end
`ifdef MUL_DIV_SDIV_EN
            SIGNFIX: state_d = FINISH;
`endif
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state_q == MUL) || (state_q == DIV) || (state_q == SIGNFIX);
        Done      = (state_q == FINISH);
        DivByZero = Done && dbz_q;
        Result    = result_q;
    end

    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        dbz_d    = dbz_q;
        result_d = result_q;
`ifdef MUL_DIV_SDIV_EN
        sdiv_d   = sdiv_q;
        neg_d    = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    acc_d = {64'd0, A};
                    b_d   = B;
                    cnt_d = '0;
                    dbz_d = is_div && (B == '0);
`ifdef MUL_DIV_SDIV_EN
                    sdiv_d = (Op == OP_SDIV);
                    neg_d  = A[63] ^ B[63];
                    if (Op == OP_SDIV) begin
                        acc_d[63:0] = A[63] ? -A : A;
                        b_d         = B[63] ? -B : B;
                    end
`endif
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[63:1]};
                cnt_d = cnt_q + 7'd1;
            end
            DIV: begin
                if (!div_diff[64]) begin
                    acc_d = {div_diff[63:0], acc_q[62:0], 1'b1};
                end else begin
                    acc_d = {div_rem[63:0], acc_q[62:0], 1'b0};
                end
                cnt_d = cnt_q + 7'd1;
            end
`ifdef MUL_DIV_SDIV_EN
            SIGNFIX: begin
                if (neg_q) acc_d[63:0] = -acc_q[63:0];
            end
`endif
            default: ;
        endcase
        // Zero-divisor and reserved ops jump straight from IDLE with Result = 0
        if ((state_d == FINISH) && (state_q != FINISH)) begin
            result_d = (state_q == IDLE) ? 64'd0 : acc_d[63:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            dbz_q    <= 1'b0;
            result_q <= '0;
`ifdef MUL_DIV_SDIV_EN
            sdiv_q   <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
`ifdef MUL_DIV_SDIV_EN
            sdiv_q   <= sdiv_d;
            neg_q    <= neg_d;
`endif
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; SDIV expectations follow
// MUL_DIV_SDIV_EN.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic        DivByZero;

    int n_checks = 0;
    int n_pass   = 0;

    mul_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then watch cycles N+1.. for Done.
    // intr_k: cycle at which a stray Start (MUL 3*3) is driven.
    // poke: drive Start in the Done cycle and expect it ignored.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat,
                          input logic exp_dbz, input int intr_k,
                          input bit poke);
        int          lat;
        bit          win_ok;
        logic [63:0] res;
        logic        dbz;
        lat    = 0;
        win_ok = 1'b1;
        res    = '0;
        dbz    = 1'b0;
        @(negedge clk);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        step();
        Start = 1'b0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            if (Done === 1'b1) begin
                lat = k;
                res = Result;
                dbz = DivByZero;
                if (Busy !== 1'b0) win_ok = 1'b0;
            end else begin
                if (Busy !== 1'b1) win_ok = 1'b0;
                if (DivByZero !== 1'b0) win_ok = 1'b0;
            end
            if (k == intr_k) begin
                Start = 1'b1;
                Op    = 2'b00;
                A     = 64'd3;
                B     = 64'd3;
            end else begin
                Start = 1'b0;
            end
            if (lat == 0) step();
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, res, exp_res);
        check({tag, "_dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
        check({tag, "_busywin"}, {63'd0, win_ok}, 64'd1);
        if (poke) begin
            Start = 1'b1;
            Op    = 2'b00;
            A     = 64'd1;
            B     = 64'd1;
        end
        step();
        Start = 1'b0;
        if (poke) check({tag, "_poke_busy"}, {63'd0, Busy}, 64'd0);
        check({tag, "_done_once"}, {63'd0, Done}, 64'd0);
        check({tag, "_dbz_low"}, {63'd0, DivByZero}, 64'd0);
        step();
        check({tag, "_held"}, Result, exp_res);
    endtask

    initial begin
        int done_seen;
        reset = 1'b1;
        step();
        step();
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_result", Result, 64'd0);
        check("rst_dbz", {63'd0, DivByZero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        run_op("mul7x6", 2'b00, 64'd7, 64'd6, 64'd42, 65, 1'b0, 0, 1'b0);
        run_op("mulwrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0, 0, 1'b0);
        run_op("udiv100_7", 2'b01, 64'd100, 64'd7, 64'd14, 65, 1'b0, 0, 1'b0);
        run_op("udivmax_2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'h7FFF_FFFF_FFFF_FFFF, 65, 1'b0, 0, 1'b0);
`ifdef MUL_DIV_SDIV_EN
        run_op("sdiv_m100_7", 2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFF2, 66, 1'b0, 0, 1'b0);
        run_op("sdiv_min_m1", 2'b10, 64'h8000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 66, 1'b0,
               0, 1'b0);
`else
        run_op("sdiv_off", 2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'd0, 1, 1'b0, 0, 1'b0);
`endif
        run_op("udiv_by0", 2'b01, 64'd5, 64'd0, 64'd0, 1, 1'b1, 0, 1'b0);
        run_op("rsvd", 2'b11, 64'd5, 64'd9, 64'd0, 1, 1'b0, 0, 1'b0);
        run_op("mul_ignore", 2'b00, 64'd7, 64'd6, 64'd42, 65, 1'b0, 10, 1'b0);
        run_op("mul_poke", 2'b00, 64'd5, 64'd5, 64'd25, 65, 1'b0, 0, 1'b1);

        // Abort a MUL with reset in cycle N+30
        @(negedge clk);
        Start = 1'b1;
        Op    = 2'b00;
        A     = 64'd7;
        B     = 64'd6;
        step();
        Start = 1'b0;
        for (int k = 1; k < 30; k++) step();
        reset = 1'b1;
        step();
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_result", Result, 64'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 80; k++) begin
            if (Done === 1'b1) done_seen++;
            step();
        end
        check("abort_nodone", 64'(done_seen), 64'd0);
        run_op("udiv9_3", 2'b01, 64'd9, 64'd3, 64'd3, 65, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
